// File: rtl/result_bcd_display.sv
// ============================================================================
// Module : result_bcd_display
// Desc   : Shift-and-add-3 binary-to-BCD converter with a multiplexed 3-digit
//          7-segment display. Define LEADING_ZERO_BLANK_EN to blank leading 0s.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module result_bcd_display #(
  parameter int REFRESH_DIV = 16
) (
  input  logic       clk,
  input  logic       restart,
  input  logic       done,
  input  logic [7:0] sum,
  output logic [3:0] bcd_hundreds,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       valid,
  output logic       busy,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int c_CNT_W = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_done_q;
  logic                w_trigger;
  logic [7:0]          r_shift;
  logic [11:0]         r_scratch;
  logic [3:0]          r_shift_cnt;
  logic [11:0]         w_adj;
  logic [c_CNT_W-1:0]  r_refresh_cnt;
  logic [1:0]          r_digit_sel;
  logic [3:0]          w_digit;
  logic                w_blank;
  logic [6:0]          w_seg;
  logic [2:0]          w_an;

  assign w_trigger = done & ~r_done_q;

  // Add-3 correction applied to every scratch nibble before the shift.
  always_comb begin
    w_adj = r_scratch;
    if (r_scratch[3:0]  >= 4'd5) w_adj[3:0]  = r_scratch[3:0]  + 4'd3;
    if (r_scratch[7:4]  >= 4'd5) w_adj[7:4]  = r_scratch[7:4]  + 4'd3;
    if (r_scratch[11:8] >= 4'd5) w_adj[11:8] = r_scratch[11:8] + 4'd3;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_trigger) w_state_nxt = CONVERT;
      CONVERT: if (r_shift_cnt == 4'd7) w_state_nxt = UPDATE;
      UPDATE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!restart) begin
      r_state      <= IDLE;
      r_done_q     <= 1'b1;
      r_shift      <= 8'd0;
      r_scratch    <= 12'd0;
      r_shift_cnt  <= 4'd0;
      bcd_hundreds <= 4'd0;
      bcd_tens     <= 4'd0;
      bcd_ones     <= 4'd0;
      valid        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_done_q <= done;
      valid    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_shift     <= sum;
            r_scratch   <= 12'd0;
            r_shift_cnt <= 4'd0;
            busy        <= 1'b1;
          end
        end
        CONVERT: begin
          {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
          r_shift_cnt          <= r_shift_cnt + 4'd1;
        end
        UPDATE: begin
          bcd_hundreds <= r_scratch[11:8];
          bcd_tens     <= r_scratch[7:4];
          bcd_ones     <= r_scratch[3:0];
          valid        <= 1'b1;
          busy         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Display refresh runs regardless of converter activity.
  always_ff @(posedge clk) begin
    if (!restart) begin
      r_refresh_cnt <= '0;
      r_digit_sel   <= 2'd0;
    end else if (r_refresh_cnt == c_CNT_W'(REFRESH_DIV - 1)) begin
      r_refresh_cnt <= '0;
      r_digit_sel   <= (r_digit_sel == 2'd2) ? 2'd0 : r_digit_sel + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + c_CNT_W'(1);
    end
  end

  always_comb begin
    w_an    = 3'b110;
    w_digit = bcd_ones;
    case (r_digit_sel)
      2'd1: begin w_an = 3'b101; w_digit = bcd_tens;     end
      2'd2: begin w_an = 3'b011; w_digit = bcd_hundreds; end
      default: ;
    endcase
  end

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    w_blank = ((r_digit_sel == 2'd2) && (bcd_hundreds == 4'd0)) ||
              ((r_digit_sel == 2'd1) && (bcd_hundreds == 4'd0) && (bcd_tens == 4'd0));
`else
    w_blank = 1'b0;
`endif
  end

  always_comb begin
    w_seg = 7'b1111111;
    if (!w_blank) begin
      case (w_digit)
        4'd0: w_seg = 7'b1000000;
        4'd1: w_seg = 7'b1111001;
        4'd2: w_seg = 7'b0100100;
        4'd3: w_seg = 7'b0110000;
        4'd4: w_seg = 7'b0011001;
        4'd5: w_seg = 7'b0010010;
        4'd6: w_seg = 7'b0000010;
        4'd7: w_seg = 7'b1111000;
        4'd8: w_seg = 7'b0000000;
        4'd9: w_seg = 7'b0010000;
        default: w_seg = 7'b1111111;
      endcase
    end
  end

  assign seg = w_seg;
  assign an  = w_an;

endmodule

`default_nettype wire

// File: doc/result_bcd_display.md
RESULT_BCD_DISPLAY -- requirements
Module: result_bcd_display

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 16, the number of clock cycles each display digit stays enabled (legal range 2..65535).
REQ-002 SHALL provide port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port restart, input, 1 bit, the reset; synchronous and active-low.
REQ-004 SHALL provide port done, input, 1 bit, the completion flag from the upstream datapath.
REQ-005 SHALL provide port sum, input, 8 bits, the unsigned result from the upstream datapath.
REQ-006 SHALL provide port bcd_hundreds, output, 4 bits, the hundreds digit of the last converted result.
REQ-007 SHALL provide port bcd_tens, output, 4 bits, the tens digit of the last converted result.
REQ-008 SHALL provide port bcd_ones, output, 4 bits, the ones digit of the last converted result.
REQ-009 SHALL provide port valid, output, 1 bit, a one-cycle pulse when new digits are published.
REQ-010 SHALL provide port busy, output, 1 bit, high while a conversion is in progress.
REQ-011 SHALL provide port seg, output, 7 bits, active-low segments ordered gfedcba (seg[6]=g).
REQ-012 SHALL provide port an, output, 3 bits, active-low one-hot digit enable: an[0]=ones, an[1]=tens, an[2]=hundreds.

Function
REQ-013 SHALL register done into done_q every cycle and define a trigger as done=1 with done_q=0.
REQ-014 SHALL use FSM states IDLE, CONVERT and UPDATE: IDLE goes to CONVERT on trigger; CONVERT goes to UPDATE after the 8th shift; UPDATE goes to IDLE unconditionally.
REQ-015 SHALL capture sum into an 8-bit shift register and clear a 12-bit BCD scratch register and a shift counter on the trigger edge while in IDLE.
REQ-016 SHALL, on each CONVERT cycle, add 3 to every scratch nibble with value >= 5 and then shift {scratch, shift register} left by one bit, for exactly 8 cycles.
REQ-017 SHALL copy the scratch nibbles to bcd_hundreds, bcd_tens and bcd_ones on the UPDATE edge, which is the 9th rising edge after the capture edge, and drive valid=1 for exactly the following cycle.
REQ-018 SHALL drive busy=1 from the capture edge until the UPDATE edge and busy=0 otherwise.
REQ-019 SHALL ignore any trigger that occurs while the FSM is not in IDLE; such triggers SHALL NOT be queued.
REQ-020 SHALL produce only one conversion while done is held high, with no retrigger.
REQ-021 SHALL hold bcd_* stable between UPDATE edges; bcd_hundreds SHALL be at most 2 for all 8-bit inputs.
REQ-022 SHALL implement a refresh counter counting 0..REFRESH_DIV-1; when it wraps, the digit select advances ones -> tens -> hundreds -> ones.
REQ-023 SHALL drive seg as the 7-segment decode of the selected bcd_* digit (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000).
REQ-024 SHALL drive an combinationally from the digit select, so that exactly one bit is low at all times.
REQ-025 SHALL keep the display refresh free-running, independent of the FSM state.

Reset
REQ-026 SHALL, when restart=0 at a rising clk edge, set the state to IDLE, all bcd_* outputs to 0, valid=0, busy=0, done_q=1, the refresh counter to 0 and the digit select to ones (an=110, seg=1000000).
REQ-027 SHALL abort any in-progress conversion on reset without publishing it.
REQ-028 SHALL NOT treat a done held high through reset release as a trigger, because done_q resets to 1.

Configuration
REQ-029 SHALL, when macro LEADING_ZERO_BLANK_EN is defined, drive seg=1111111 for the hundreds digit when bcd_hundreds=0, and for the tens digit when bcd_hundreds=0 and bcd_tens=0.
REQ-030 SHALL never blank the ones digit; an sequencing SHALL be unchanged by blanking.
REQ-031 SHALL, when LEADING_ZERO_BLANK_EN is undefined, always decode all three digits.

Verification
REQ-032 SHALL verify: sum=255 with a done rising edge -> 9 edges later bcd=2/5/5, valid high for exactly 1 cycle, busy high for 9 cycles.
REQ-033 SHALL verify: sum=0 converted -> bcd=0/0/0; with LEADING_ZERO_BLANK_EN, hundreds and tens seg=1111111 and ones seg=1000000; without it, all three digits show seg=1000000.
REQ-034 SHALL verify: sum=7 with done held high for 30 cycles -> exactly one valid pulse and bcd=0/0/7.
REQ-035 SHALL verify: sum=100 converted, with a second done rising edge carrying sum=42 three cycles later -> bcd=1/0/0, a single valid pulse, and 42 never published.
REQ-036 SHALL verify: restart=0 on the 4th CONVERT cycle of sum=199 -> bcd=0/0/0, busy=0, no valid; a subsequent done edge with sum=199 -> bcd=1/9/9.
REQ-037 SHALL verify: with REFRESH_DIV=4 -> an cycles 110, 101, 011 with 4 cycles each, repeating, and seg matching the selected digit in every cycle.
